rx_pydeser: RTL and testbench
=============================

Name: rx_pydeser

Overview:
- Receive-side payload deserializer directly downstream of the payload bit processor (CRC16 / de-whitening / FEC 2/3 decode).
- Consumes the de-whitened, FEC-corrected payload bit stream one bit per strobe.
- Parses the ACL payload header (1- or 2-byte) and packs the payload body LSB-first into bytes written to the RX payload buffer.
- Counts the 16 trailing CRC bits and reports a completion pulse with CRC verdict and length error.

Parameters:
- MAXLEN, 1021, largest legal payload body length in bytes; longer headers flag len_err.
- AW, 10, RX buffer byte-address width.

Ports:
- clk_6M  in  1  system clock.
- rstz  in  1  asynchronous active-low reset.
- pk_encode  in  1  1 = TX mode; the block ignores all inputs and holds IDLE.
- dec_py_st_p  in  1  payload start pulse; (re)starts parsing.
- pybit_valid_p  in  1  one-cycle strobe: pybit is valid.
- pybit  in  1  decoded payload bit, LSB first.
- hdr2byte  in  1  1 = multi-slot 2-byte header; sampled at dec_py_st_p.
- dec_py_endp  in  1  payload bit-stream end pulse.
- crc_rdy_p  in  1  pulse, two cycles after dec_py_endp: dec_crcgood is valid.
- dec_crcgood  in  1  CRC16 remainder == 0.
- rx_llid  out  2  header LLID.
- rx_flow  out  1  header FLOW.
- rx_length  out  10  header LENGTH (upper 5 bits zero for 1-byte header).
- hdr_valid_p  out  1  header-complete pulse.
- wr_en_p  out  1  byte write strobe.
- wr_addr  out  AW  byte address, starts at 0 for each payload.
- wr_data  out  8  assembled byte.
- py_done_p  out  1  payload complete.
- rx_crcpass  out  1  latched CRC verdict.
- len_err  out  1  latched length/short-stream error.

Behaviour:
- Reset value 0 for all outputs; state IDLE; bit and byte counters 0.
- Accepted bit: a cycle with pybit_valid_p=1 while not in IDLE/WAITCRC.
- States and transitions:
  - IDLE -> HDR on dec_py_st_p with pk_encode=0.
  - HDR: shift bits into a 16-bit header register, LSB first. After 8 bits (hdr2byte=0) or 16 bits (hdr2byte=1):
    - Decode LLID = bits[1:0], FLOW = bit[2].
    - LENGTH = bits[7:3] for a 1-byte header, bits[12:3] for a 2-byte header; bits[15:13] are ignored.
    - Register fields and pulse hdr_valid_p in the next cycle.
    - Go to DATA if LENGTH != 0, else CRC.
  - DATA: shift bits into the byte register, bit0 first. On the 8th bit, in the next cycle:
    - wr_en_p=1, wr_data = byte, wr_addr = byte count.
    - Then increment byte count.
    - When byte count reaches LENGTH, go to CRC.
  - CRC: count 16 bits, then WAITCRC. Bits are discarded.
  - WAITCRC: on crc_rdy_p, latch rx_crcpass = dec_crcgood, pulse py_done_p one cycle later, return to IDLE.
- dec_py_endp in HDR, DATA or CRC before the expected bit count:
  - Set len_err=1 and go to WAITCRC.
  - A partial byte is dropped, never written.
- dec_py_endp in the same cycle as the final expected bit: the bit is accepted; no error.
- LENGTH > MAXLEN: len_err=1; behaviour otherwise per the Optional Feature.
- dec_py_st_p in any non-IDLE state:
  - Abort, clear counters/len_err/rx_crcpass, enter HDR.
  - Abort wins over a coincident bit strobe; that bit is dropped.
- crc_rdy_p outside WAITCRC: ignored.
- pk_encode=1 at any time: return to IDLE within one cycle; no writes or pulses.
- rx_llid/rx_flow/rx_length/rx_crcpass/len_err hold until the next dec_py_st_p.
- Latency:
  - Last bit of a byte -> wr_en_p: 1 cycle.
  - Last header bit -> hdr_valid_p: 1 cycle.
  - crc_rdy_p -> py_done_p: 1 cycle.

Optional Feature:
- Macro RX_PYDESER_LEN_CLIP_EN.
- Defined: when LENGTH > MAXLEN, byte writes stop after MAXLEN bytes; surplus body bits are counted but not written, so wr_addr never exceeds MAXLEN-1.
- Undefined: all LENGTH bytes are written and wr_addr wraps modulo 2^AW; len_err still flags.

Decomposition:
- Shared package rx_py_pkg holds:
  - state encoding (IDLE, HDR, DATA, CRC, WAITCRC);
  - header field offsets and widths;
  - CRC_BITS=16;
  - LLID constants (01 continuation, 10 start, 11 LMP).
- One natural sub-module, rx_py_bytepack: 8-bit LSB-first shift register plus 3-bit counter, emitting byte_rdy_p and data. The FSM and counters stay in the top level.

Test Plan:
- 1-byte header 0x1A (LLID=10, FLOW=0, LEN=3), body 0x55,0xA3,0x0F, 16 CRC bits, crc_rdy_p with dec_crcgood=1 -> hdr_valid_p with rx_length=3; writes addr0=0x55, addr1=0xA3, addr2=0x0F; py_done_p; rx_crcpass=1; len_err=0.
- 2-byte header, LEN=339, random body, dec_crcgood=0 -> exactly 339 writes at addr 0..338; rx_crcpass=0.
- Header LEN=0, then 16 CRC bits -> hdr_valid_p, no wr_en_p, py_done_p after crc_rdy_p.
- LEN=5 but dec_py_endp after 2 bytes + 4 bits -> 2 writes; len_err=1; py_done_p after crc_rdy_p.
- dec_py_st_p mid-DATA of LEN=4 after 1 byte, then a new LEN=1 payload 0xC3 -> new write at addr0=0xC3; len_err=0.
- MAXLEN=8, LEN=10 -> len_err=1. With the macro: 8 writes. Without the macro: 10 writes, addr 0..9.

Source files
------------

// File: rtl/rx_py_pkg.sv
// rx_py_pkg: shared states, header field layout and LLID codes for the RX payload deserializer
package rx_py_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, WAITCRC} state_t;
  localparam int LLID_LSB = 0;
  localparam int LLID_W = 2;
  localparam int FLOW_BIT = 2;
  localparam int LEN_LSB = 3;
  localparam int LEN1_W = 5;
  localparam int LEN2_W = 10;
  localparam int CRC_BITS = 16;
  localparam logic [1:0] LLID_CONT = 2'b01;
  localparam logic [1:0] LLID_START = 2'b10;
  localparam logic [1:0] LLID_LMP = 2'b11;
endpackage

// File: rtl/rx_py_bytepack.sv
// rx_py_bytepack: LSB-first 8-bit shift register with bit counter, pulses byte_rdy_p after the 8th bit
module rx_py_bytepack (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic       byte_rdy_p,
  output logic       last,
  output logic [7:0] data
);
  logic [2:0] cnt;
  assign last = cnt == 3'd7;
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) begin
      cnt <= '0;
      data <= '0;
      byte_rdy_p <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      byte_rdy_p <= 1'b0;
    end else begin
      byte_rdy_p <= bit_en & last;
      if (bit_en) begin
        data <= {bit_in, data[7:1]};
        cnt <= cnt + 3'd1;
      end
    end
endmodule

// File: rtl/rx_pydeser.sv
// rx_pydeser: parses the ACL payload header, packs body bytes into the RX buffer and reports CRC/length status
// Define RX_PYDESER_LEN_CLIP_EN to stop buffer writes after MAXLEN bytes on oversize headers.
module rx_pydeser import rx_py_pkg::*; #(
  parameter int MAXLEN = 1021,
  parameter int AW = 10
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              pk_encode,
  input  logic              dec_py_st_p,
  input  logic              pybit_valid_p,
  input  logic              pybit,
  input  logic              hdr2byte,
  input  logic              dec_py_endp,
  input  logic              crc_rdy_p,
  input  logic              dec_crcgood,
  output logic [1:0]        rx_llid,
  output logic              rx_flow,
  output logic [9:0]        rx_length,
  output logic              hdr_valid_p,
  output logic              wr_en_p,
  output logic [AW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  output logic              py_done_p,
  output logic              rx_crcpass,
  output logic              len_err
);
  localparam logic [LEN2_W-1:0] MAXLEN_V = LEN2_W'(MAXLEN);
  state_t state, state_nx;
  logic hdr2, start, busy, acc, hdr_last, crc_last, byte_last, early_end, crc_take;
  logic bp_rdy, bp_last, bp_clr;
  logic [3:0] cnt;
  logic [15:0] hdr, hdr_nx;
  logic [LEN2_W-1:0] len_nx, bcnt;
  assign start = dec_py_st_p & ~pk_encode;
  assign busy = state inside {HDR, DATA, CRC};
  assign acc = pybit_valid_p & busy & ~start & ~pk_encode;
  assign hdr_last = acc & (state == HDR) & (cnt == (hdr2 ? 4'd15 : 4'd7));
  assign crc_last = acc & (state == CRC) & (cnt == 4'(CRC_BITS - 1));
  assign byte_last = acc & (state == DATA) & bp_last & (bcnt + 1'b1 == rx_length);
  // an end pulse on the very last CRC bit is a clean finish, anything earlier is short
  assign early_end = dec_py_endp & busy & ~start & ~pk_encode & ~crc_last;
  assign crc_take = (state == WAITCRC) & crc_rdy_p & ~start & ~pk_encode;
  always_comb begin
    hdr_nx = hdr;
    hdr_nx[cnt] = pybit;
    len_nx = hdr2 ? hdr_nx[LEN_LSB +: LEN2_W] : LEN2_W'(hdr_nx[LEN_LSB +: LEN1_W]);
  end
  always_comb begin
    state_nx = state;
    if (pk_encode) state_nx = IDLE;
    else if (start) state_nx = HDR;
    else if (early_end) state_nx = WAITCRC;
    else if (hdr_last) state_nx = (len_nx != '0) ? DATA : CRC;
    else if (byte_last) state_nx = CRC;
    else if (crc_last) state_nx = WAITCRC;
    else if (crc_take) state_nx = IDLE;
  end
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) begin
      hdr2 <= 1'b0;
      cnt <= '0;
      hdr <= '0;
      bcnt <= '0;
      rx_llid <= '0;
      rx_flow <= 1'b0;
      rx_length <= '0;
      hdr_valid_p <= 1'b0;
      py_done_p <= 1'b0;
      rx_crcpass <= 1'b0;
      len_err <= 1'b0;
    end else begin
      hdr_valid_p <= hdr_last;
      py_done_p <= crc_take;
      if (start) begin
        hdr2 <= hdr2byte;
        cnt <= '0;
        hdr <= '0;
        bcnt <= '0;
        rx_crcpass <= 1'b0;
        len_err <= 1'b0;
      end else begin
        if (acc && state != DATA) cnt <= hdr_last ? 4'd0 : cnt + 4'd1;
        if (acc && state == HDR) hdr <= hdr_nx;
        if (hdr_last) begin
          rx_llid <= hdr_nx[LLID_LSB +: LLID_W];
          rx_flow <= hdr_nx[FLOW_BIT];
          rx_length <= len_nx;
        end
        if (early_end || (hdr_last && len_nx > MAXLEN_V)) len_err <= 1'b1;
        if (bp_rdy) bcnt <= bcnt + 1'b1;
        if (crc_take) rx_crcpass <= dec_crcgood;
      end
    end
  assign bp_clr = (state != DATA) | start | pk_encode;
  rx_py_bytepack u_bytepack (
    .clk_6M    (clk_6M),
    .rstz      (rstz),
    .clr       (bp_clr),
    .bit_en    (acc & (state == DATA)),
    .bit_in    (pybit),
    .byte_rdy_p(bp_rdy),
    .last      (bp_last),
    .data      (wr_data)
  );
`ifdef RX_PYDESER_LEN_CLIP_EN
  assign wr_en_p = bp_rdy & ~pk_encode & (bcnt < MAXLEN_V);
`else
  assign wr_en_p = bp_rdy & ~pk_encode;
`endif
  assign wr_addr = AW'(bcnt);
endmodule

// File: tb/tb_rx_pydeser.sv
// tb_rx_pydeser: directed and random payloads against a bit-list reference model, two MAXLEN builds side by side
module tb_rx_pydeser;
  import rx_py_pkg::*;
  logic clk_6M = 1'b0, rstz = 1'b0;
  logic pk_encode = 0, dec_py_st_p = 0, pybit_valid_p = 0, pybit = 0, hdr2byte = 0;
  logic dec_py_endp = 0, crc_rdy_p = 0, dec_crcgood = 0;
  logic [1:0] rx_llid_a, rx_llid_b;
  logic rx_flow_a, rx_flow_b, hv_p_a, hv_p_b, wr_en_a, wr_en_b, done_p_a, done_p_b;
  logic crcpass_a, crcpass_b, len_err_a, len_err_b;
  logic [9:0] rx_length_a, rx_length_b, wr_addr_a, wr_addr_b;
  logic [7:0] wr_data_a, wr_data_b;
  int n_chk = 0, n_fail = 0;
  int hv_a, hv_b, done_a, done_b;
  logic [9:0] wa_a[$], wa_b[$];
  logic [7:0] wd_a[$], wd_b[$];
  logic [7:0] body[$];

  always #5 clk_6M = ~clk_6M;

  rx_pydeser dut (
    .clk_6M(clk_6M), .rstz(rstz), .pk_encode(pk_encode), .dec_py_st_p(dec_py_st_p),
    .pybit_valid_p(pybit_valid_p), .pybit(pybit), .hdr2byte(hdr2byte), .dec_py_endp(dec_py_endp),
    .crc_rdy_p(crc_rdy_p), .dec_crcgood(dec_crcgood), .rx_llid(rx_llid_a), .rx_flow(rx_flow_a),
    .rx_length(rx_length_a), .hdr_valid_p(hv_p_a), .wr_en_p(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .py_done_p(done_p_a), .rx_crcpass(crcpass_a), .len_err(len_err_a));

  rx_pydeser #(.MAXLEN(8)) dut_b (
    .clk_6M(clk_6M), .rstz(rstz), .pk_encode(pk_encode), .dec_py_st_p(dec_py_st_p),
    .pybit_valid_p(pybit_valid_p), .pybit(pybit), .hdr2byte(hdr2byte), .dec_py_endp(dec_py_endp),
    .crc_rdy_p(crc_rdy_p), .dec_crcgood(dec_crcgood), .rx_llid(rx_llid_b), .rx_flow(rx_flow_b),
    .rx_length(rx_length_b), .hdr_valid_p(hv_p_b), .wr_en_p(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .py_done_p(done_p_b), .rx_crcpass(crcpass_b), .len_err(len_err_b));

  always @(negedge clk_6M) begin
    if (wr_en_a) begin wa_a.push_back(wr_addr_a); wd_a.push_back(wr_data_a); end
    if (wr_en_b) begin wa_b.push_back(wr_addr_b); wd_b.push_back(wr_data_b); end
    hv_a += int'(hv_p_a);
    hv_b += int'(hv_p_b);
    done_a += int'(done_p_a);
    done_b += int'(done_p_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    hv_a = 0; hv_b = 0; done_a = 0; done_b = 0;
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  // mode 0: full stream, 1: dec_py_endp after 'cut' bits, 2: stop after 'cut' bits (next start aborts)
  task automatic run_py(input string tag, input logic h2, input logic [1:0] llid, input logic flow,
                        input logic [9:0] len, input int mode, input int cut, input logic good);
    logic bits[$];
    logic [15:0] h;
    int nh, nb, sent, ea, eb, bad;
    nh = h2 ? 16 : 8;
    h = {3'($urandom), len, flow, llid};
    for (int i = 0; i < nh; i++) bits.push_back(h[i]);
    foreach (body[k]) for (int j = 0; j < 8; j++) bits.push_back(body[k][j]);
    for (int i = 0; i < 16; i++) bits.push_back(1'($urandom));
    nb = (mode == 0) ? bits.size() : cut;
    clear_logs();
    dec_py_st_p = 1; hdr2byte = h2;
    tick();
    dec_py_st_p = 0; hdr2byte = 0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      pybit_valid_p = 1; pybit = bits[i];
      dec_py_endp = (mode == 0) && (i == nb - 1);
      tick();
      pybit_valid_p = 0; dec_py_endp = 0; pybit = 1'($urandom);
    end
    if (mode == 1) begin
      dec_py_endp = 1;
      tick();
      dec_py_endp = 0;
    end
    if (mode != 2) begin
      tick();
      crc_rdy_p = 1; dec_crcgood = good;
      tick();
      crc_rdy_p = 0; dec_crcgood = 1'($urandom);
    end
    repeat (3) tick();
    sent = (nb > nh) ? (nb - nh) / 8 : 0;
    if (sent > int'(len)) sent = int'(len);
    ea = sent;
    eb = sent;
`ifdef RX_PYDESER_LEN_CLIP_EN
    if (eb > 8) eb = 8;
`endif
    chk({tag, " writes_a"}, wa_a.size(), ea);
    chk({tag, " writes_b"}, wa_b.size(), eb);
    bad = 0;
    for (int i = 0; i < wa_a.size() && i < ea; i++)
      if (wa_a[i] !== 10'(i) || wd_a[i] !== body[i]) bad++;
    chk({tag, " wr_content_a"}, bad, 0);
    bad = 0;
    for (int i = 0; i < wa_b.size() && i < eb; i++)
      if (wa_b[i] !== 10'(i) || wd_b[i] !== body[i]) bad++;
    chk({tag, " wr_content_b"}, bad, 0);
    chk({tag, " hdr_valid_a"}, hv_a, 1);
    chk({tag, " hdr_valid_b"}, hv_b, 1);
    chk({tag, " rx_llid"}, rx_llid_a, llid);
    chk({tag, " rx_flow"}, rx_flow_a, flow);
    chk({tag, " rx_length"}, rx_length_a, h2 ? len : {5'b0, len[4:0]});
    if (mode != 2) begin
      chk({tag, " py_done_a"}, done_a, 1);
      chk({tag, " py_done_b"}, done_b, 1);
      chk({tag, " rx_crcpass"}, crcpass_a, good);
      chk({tag, " len_err_a"}, len_err_a, (mode == 1) || (len > 10'd1021));
      chk({tag, " len_err_b"}, len_err_b, (mode == 1) || (len > 10'd8));
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst wr_en", wr_en_a, 0);
    chk("rst hdr_valid", hv_p_a, 0);
    chk("rst py_done", done_p_a, 0);
    chk("rst rx_length", rx_length_a, 0);
    chk("rst len_err", len_err_a, 0);
    chk("rst crcpass", crcpass_a, 0);
    chk("rst wr_addr", wr_addr_a, 0);
    rstz = 1;
    repeat (2) tick();

    body = '{8'h55, 8'hA3, 8'h0F};
    run_py("basic", 0, LLID_START, 0, 10'd3, 0, 0, 1);

    body.delete();
    for (int i = 0; i < 339; i++) body.push_back(8'($urandom));
    run_py("hdr2_339", 1, LLID_CONT, 1'($urandom), 10'd339, 0, 0, 0);

    body.delete();
    run_py("len0", 0, LLID_LMP, 1, 10'd0, 0, 0, 1);

    body.delete();
    for (int i = 0; i < 5; i++) body.push_back(8'($urandom));
    run_py("short", 0, LLID_START, 0, 10'd5, 1, 8 + 16 + 4, 1);

    body.delete();
    for (int i = 0; i < 4; i++) body.push_back(8'($urandom));
    run_py("abort", 0, LLID_START, 0, 10'd4, 2, 8 + 8 + 3, 1);
    body = '{8'hC3};
    run_py("after_abort", 0, LLID_START, 0, 10'd1, 0, 0, 1);

    body.delete();
    for (int i = 0; i < 10; i++) body.push_back(8'($urandom));
    run_py("oversize", 0, LLID_START, 1, 10'd10, 0, 0, 1);

    clear_logs();
    pk_encode = 1;
    dec_py_st_p = 1;
    tick();
    dec_py_st_p = 0;
    for (int i = 0; i < 24; i++) begin
      pybit_valid_p = 1; pybit = 1'($urandom);
      tick();
    end
    pybit_valid_p = 0;
    dec_py_endp = 1;
    tick();
    dec_py_endp = 0;
    tick();
    crc_rdy_p = 1;
    tick();
    crc_rdy_p = 0;
    repeat (3) tick();
    chk("tx hdr_valid", hv_a, 0);
    chk("tx writes", wa_a.size(), 0);
    chk("tx py_done", done_a, 0);
    pk_encode = 0;
    tick();

    for (int r = 0; r < 6; r++) begin
      logic h2;
      logic [9:0] len;
      h2 = 1'($urandom);
      len = 10'($urandom_range(0, h2 ? 40 : 31));
      body.delete();
      for (int i = 0; i < int'(len); i++) body.push_back(8'($urandom));
      run_py("rand", h2, 2'($urandom), 1'($urandom), len, 0, 0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
